// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
//
// Parametrised RS-232 transmitter. Serialises one DATA_BITS-wide word per
// accepted request, LSB first, framed as: start bit (0), data bits, optional
// parity bit, STOP_BITS stop bits (1). The bit period is chosen at runtime
// from an eight-entry baud table and is latched together with the data word,
// so mid-frame input changes only affect the next frame. Holding send_en high
// produces back-to-back frames separated by the single Tx_Done cycle.
//
// Parameters:
//   CLK_FREQ   input clock frequency in Hz
//   DATA_BITS  data bits per frame (5..9)
//   PARITY     0 = none, 1 = odd, 2 = even
//   STOP_BITS  1 or 2
//
// Ports:
//   Clk         system clock, rising edge
//   Rst_n       asynchronous active-low reset
//   data_byte   word to transmit, sampled at acceptance
//   send_en     transmit request (level), ignored while a frame is running
//   baud_set    baud select 0..7 (9600..921600), sampled at acceptance
//   Rs232_Tx    serial line output, idles high (registered)
//   Tx_Done     one-cycle pulse in the cycle after the last stop-bit clock
//   uart_state  high while a frame is in progress (registered)
// -----------------------------------------------------------------------------
module uart_tx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [DATA_BITS-1:0] data_byte,
    input  logic                 send_en,
    input  logic [2:0]           baud_set,
    output logic                 Rs232_Tx,
    output logic                 Tx_Done,
    output logic                 uart_state
);

    // Wide enough for the slowest rate (9600 baud) with one bit of headroom.
    localparam int CNT_W = $clog2(CLK_FREQ / 9600) + 1;

    generate
        if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
            $error("uart_tx_param: DATA_BITS must be in 5..9");
        end
        if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
            $error("uart_tx_param: STOP_BITS must be 1 or 2");
        end
        if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
            $error("uart_tx_param: PARITY must be 0, 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    // Clocks per bit for a baud_set code.
    function automatic logic [CNT_W-1:0] bit_cycles(input logic [2:0] sel);
        int baud;
        baud = 9600;
        case (sel)
            3'd0: baud = 9600;
            3'd1: baud = 19200;
            3'd2: baud = 38400;
            3'd3: baud = 57600;
            3'd4: baud = 115200;
            3'd5: baud = 230400;
            3'd6: baud = 460800;
            3'd7: baud = 921600;
            default: baud = 9600;
        endcase
        return CNT_W'(CLK_FREQ / baud);
    endfunction

    state_t               state;
    logic [CNT_W-1:0]     div_cnt;   // clocks elapsed within the current bit
    logic [CNT_W-1:0]     bit_last;  // latched bit period minus one
    logic [DATA_BITS-1:0] shreg;     // remaining data bits, LSB next
    logic [3:0]           bit_idx;   // index of the data bit on the line
    logic                 par_bit;
    logic                 stop_cnt;  // index of the stop bit on the line
    logic                 bit_end;

    assign bit_end = (div_cnt == bit_last);

    // NOTE: every register here is state, so all assignments are non-blocking
    // and every register, not only the FSM, is cleared by the async reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_last   <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            par_bit    <= 1'b0;
            stop_cnt   <= 1'b0;
            Rs232_Tx   <= 1'b1;
            Tx_Done    <= 1'b0;
            uart_state <= 1'b0;
        end else begin
            // Tx_Done is a single-cycle pulse; only the final stop bit raises it.
            Tx_Done <= 1'b0;

            if (state == IDLE) begin
                if (send_en) begin
                    shreg      <= data_byte;
                    bit_last   <= bit_cycles(baud_set) - CNT_W'(1);
                    par_bit    <= (PARITY == 1) ? ~(^data_byte) : ^data_byte;
                    div_cnt    <= '0;
                    state      <= START;
                    Rs232_Tx   <= 1'b0;
                    uart_state <= 1'b1;
                end
            end else if (!bit_end) begin
                div_cnt <= div_cnt + CNT_W'(1);
            end else begin
                // Bit period complete: put the next bit on the line.
                div_cnt <= '0;
                case (state)
                    START: begin
                        Rs232_Tx <= shreg[0];
                        shreg    <= shreg >> 1;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end
                    DATA: begin
                        if (bit_idx == 4'(DATA_BITS - 1)) begin
                            if (PARITY != 0) begin
                                state    <= PAR;
                                Rs232_Tx <= par_bit;
                            end else begin
                                state    <= STOP;
                                Rs232_Tx <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            Rs232_Tx <= shreg[0];
                            shreg    <= shreg >> 1;
                            bit_idx  <= bit_idx + 4'd1;
                        end
                    end
                    PAR: begin
                        state    <= STOP;
                        Rs232_Tx <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (stop_cnt == 1'(STOP_BITS - 1)) begin
                            state      <= IDLE;
                            uart_state <= 1'b0;
                            Tx_Done    <= 1'b1;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        Rs232_Tx   <= 1'b1;
                        uart_state <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_param
//
// Five transmitter instances run side by side:
//   0: 8N1    single frame, back-to-back run, reset in data bit 3
//   1: 8E2    single frame with even parity and two stop bits
//   2: 8O1    single frame with odd parity
//   3: 5N1    two frames at 921600 baud
//   4: 8N1    data/baud changed mid-frame, applied to the next frame
// Stimulus pushes the hand-computed line pattern of each frame into a
// per-instance queue; a per-instance monitor reconstructs every frame it
// sees on the line and compares it with the head of that queue.
// -----------------------------------------------------------------------------
module tb_uart_tx_param;

    localparam int NI = 5;

    typedef struct {
        logic [15:0] bits;   // line levels, bit 0 = start bit
        int          n;      // bits per frame
        int          bc;     // clocks per bit
        bit          gap1;   // frame must start one clock after previous Tx_Done
        bit          abort;  // frame is cut by reset, no Tx_Done expected
    } exp_t;

    logic           clk;
    logic [NI-1:0]  rst_n;
    logic [NI-1:0]  send_en;
    logic [8:0]     data [NI];
    logic [2:0]     baud [NI];
    logic [NI-1:0]  tx;
    logic [NI-1:0]  done;
    logic [NI-1:0]  st;
    int             cyc;

    int n_cmp;
    int n_fail;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t q3[$];
    exp_t q4[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DB = (g == 3) ? 5 : 8;
        localparam int PB = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam int SB = (g == 1) ? 2 : 1;

        uart_tx_param #(
            .CLK_FREQ (50_000_000),
            .DATA_BITS(DB),
            .PARITY   (PB),
            .STOP_BITS(SB)
        ) u_dut (
            .Clk       (clk),
            .Rst_n     (rst_n[g]),
            .data_byte (data[g][DB-1:0]),
            .send_en   (send_en[g]),
            .baud_set  (baud[g]),
            .Rs232_Tx  (tx[g]),
            .Tx_Done   (done[g]),
            .uart_state(st[g])
        );
    end

    task automatic check(input string name, input int i,
                         input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s[inst %0d] at cycle %0d: got 0x%0h, want 0x%0h",
                     name, i, cyc, act, req);
        end
    endtask

    function automatic exp_t mk(input int n, input int bc, input logic [15:0] bits,
                                input bit gap1, input bit abort);
        exp_t e;
        e.bits  = bits;
        e.n     = n;
        e.bc    = bc;
        e.gap1  = gap1;
        e.abort = abort;
        return e;
    endfunction

    function automatic void push_exp(input int i, input exp_t e);
        case (i)
            0: q0.push_back(e);
            1: q1.push_back(e);
            2: q2.push_back(e);
            3: q3.push_back(e);
            default: q4.push_back(e);
        endcase
    endfunction

    function automatic void pop_exp(input int i, output exp_t e, output bit ok);
        e  = mk(1, 1, '0, 1'b0, 1'b0);
        ok = 1'b0;
        case (i)
            0: if (q0.size() > 0) begin e = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); ok = 1'b1; end
            2: if (q2.size() > 0) begin e = q2.pop_front(); ok = 1'b1; end
            3: if (q3.size() > 0) begin e = q3.pop_front(); ok = 1'b1; end
            default: if (q4.size() > 0) begin e = q4.pop_front(); ok = 1'b1; end
        endcase
    endfunction

    function automatic int qsize(input int i);
        case (i)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            3: return q3.size();
            default: return q4.size();
        endcase
    endfunction

    // Monitors: one per instance, sampling on the falling edge.
    for (genvar g = 0; g < NI; g++) begin : g_mon
        initial begin : mon
            exp_t        e;
            bit          ok;
            logic [15:0] obs;
            bit          glitch;
            int          len;
            int          bi;
            int          last_done;
            last_done = -10;
            forever begin
                @(negedge clk);
                if (rst_n[g] && st[g]) begin
                    pop_exp(g, e, ok);
                    check("frame_expected", g, 32'(ok), 1);
                    if (ok && e.gap1)
                        check("interframe_gap", g, cyc - last_done, 1);
                    obs    = '0;
                    glitch = 1'b0;
                    len    = 0;
                    while (st[g] && rst_n[g] && len < 60000) begin
                        if (ok) begin
                            bi = len / e.bc;
                            if (len % e.bc == 0) begin
                                if (bi < 16) obs[bi] = tx[g];
                            end else if (bi < 16 && tx[g] !== obs[bi]) begin
                                glitch = 1'b1;
                            end
                        end
                        if (done[g]) glitch = 1'b1;
                        len++;
                        @(negedge clk);
                    end
                    if (ok && e.abort) begin
                        check("abort_by_reset", g, 32'(rst_n[g]), 0);
                        check("abort_no_done", g, 32'(done[g]), 0);
                        check("abort_line_idle", g, 32'(tx[g]), 1);
                    end else if (ok) begin
                        check("frame_len", g, len, e.n * e.bc);
                        check("frame_bits", g, 32'(obs), 32'(e.bits));
                        check("bit_stable", g, 32'(glitch), 0);
                        check("tx_done_pulse", g, 32'(done[g]), 1);
                        check("done_line_idle", g, 32'(tx[g]), 1);
                        last_done = cyc;
                    end
                end else if (done[g]) begin
                    check("stray_done", g, 32'(done[g]), 0);
                end
            end
        end
    end

    task automatic send_pulse(input int i, input logic [8:0] d, input logic [2:0] b);
        @(negedge clk);
        data[i]    = d;
        baud[i]    = b;
        send_en[i] = 1'b1;
        @(negedge clk);
        send_en[i] = 1'b0;
    endtask

    task automatic wait_frame_end(input int i, input int bound);
        int n;
        n = 0;
        while (!st[i] && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame_start", i, 32'(st[i]), 1);
        n = 0;
        while (st[i] && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_frame_end", i, 32'(st[i]), 0);
        @(negedge clk);
    endtask

    // Watchdog: the whole run needs roughly 66k cycles.
    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run did not complete within 90000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp   = 0;
        n_fail  = 0;
        rst_n   = '0;
        send_en = '0;
        for (int i = 0; i < NI; i++) begin
            data[i] = '0;
            baud[i] = '0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("reset_tx", i, 32'(tx[i]), 1);
            check("reset_done", i, 32'(done[i]), 0);
            check("reset_state", i, 32'(st[i]), 0);
        end
        rst_n = '1;
        repeat (2) @(negedge clk);

        fork
            begin : inst0
                // 8N1, 0x91 at 38400: 0,1,0,0,0,1,0,0,1,1
                push_exp(0, mk(10, 1302, 16'b1_10010001_0, 1'b0, 1'b0));
                send_pulse(0, 9'h091, 3'd2);
                wait_frame_end(0, 20000);

                // send_en held at 115200: four frames of 4340 clocks, 1-clock gaps
                push_exp(0, mk(10, 434, 16'b1_10100101_0, 1'b0, 1'b0));
                push_exp(0, mk(10, 434, 16'b1_10100101_0, 1'b1, 1'b0));
                push_exp(0, mk(10, 434, 16'b1_10100101_0, 1'b1, 1'b0));
                push_exp(0, mk(10, 434, 16'b1_10100101_0, 1'b1, 1'b0));
                @(negedge clk);
                data[0]    = 9'h0A5;
                baud[0]    = 3'd4;
                send_en[0] = 1'b1;
                repeat (3 * 4341 + 2000) @(negedge clk);
                send_en[0] = 1'b0;
                wait_frame_end(0, 6000);

                // Reset during data bit 3 (line low there for 0x91)
                push_exp(0, mk(10, 434, 16'b1_10010001_0, 1'b0, 1'b1));
                send_pulse(0, 9'h091, 3'd4);
                repeat (4 * 434 + 100) @(negedge clk);
                check("pre_reset_line", 0, 32'(tx[0]), 0);
                #1 rst_n[0] = 1'b0;
                #1;
                check("reset_mid_tx", 0, 32'(tx[0]), 1);
                check("reset_mid_state", 0, 32'(st[0]), 0);
                check("reset_mid_done", 0, 32'(done[0]), 0);
                repeat (5) @(negedge clk);
                rst_n[0] = 1'b1;
                repeat (2) @(negedge clk);
                push_exp(0, mk(10, 434, 16'b1_00111100_0, 1'b0, 1'b0));
                send_pulse(0, 9'h03C, 3'd4);
                wait_frame_end(0, 6000);
            end
            begin : inst1
                // 8E2: three ones in 0x91 -> parity 1, then two stop bits
                push_exp(1, mk(12, 1302, 16'b11_1_10010001_0, 1'b0, 1'b0));
                send_pulse(1, 9'h091, 3'd2);
                wait_frame_end(1, 20000);
            end
            begin : inst2
                // 8O1: parity 0 for 0x91
                push_exp(2, mk(11, 1302, 16'b1_0_10010001_0, 1'b0, 1'b0));
                send_pulse(2, 9'h091, 3'd2);
                wait_frame_end(2, 20000);
            end
            begin : inst3
                // 5N1 at 921600 (54 clocks/bit): 10110 -> 0,1,1,0,1
                push_exp(3, mk(7, 54, 16'b1_10110_0, 1'b0, 1'b0));
                send_pulse(3, 9'h016, 3'd7);
                wait_frame_end(3, 1000);
                push_exp(3, mk(7, 54, 16'b1_01001_0, 1'b0, 1'b0));
                send_pulse(3, 9'h009, 3'd7);
                wait_frame_end(3, 1000);
            end
            begin : inst4
                // Mid-frame change of data/baud only affects the next frame
                push_exp(4, mk(10, 1302, 16'b1_10010001_0, 1'b0, 1'b0));
                push_exp(4, mk(10, 5208, 16'b1_00000000_0, 1'b0, 1'b0));
                send_pulse(4, 9'h091, 3'd2);
                repeat (3000) @(negedge clk);
                data[4] = 9'h000;
                baud[4] = 3'd0;
                wait_frame_end(4, 20000);
                send_pulse(4, 9'h000, 3'd0);
                wait_frame_end(4, 60000);
            end
        join

        repeat (10) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check("queue_drained", i, qsize(i), 0);
            check("final_idle", i, 32'(st[i]), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
